run_controller: RTL

//  Top-level run sequencer that sits directly upstream of the control unit and drives its status[1:0] input.

---
 rtl/run_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// Run sequencer ahead of the control unit: IDLE -> SETTLE -> RUN -> READOUT -> DONE, with a RUN cycle counter.
// Optional watchdog (ERROR state, timeout output) is compiled in when WATCHDOG_EN is defined.
module run_controller #(
    parameter int CNT_W       = 24,
    parameter int MAX_CYCLES  = 1000000,
    parameter int LOAD_SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_done_i,
    input  logic             start_req_i,
    input  logic             end_process_i,
    input  logic             readout_done_i,
    output logic [1:0]       status_o,
    output logic             readout_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic             timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_RUN     = 3'd2,
        S_READOUT = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

`ifdef WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    localparam int SW = (LOAD_SETTLE > 1) ? $clog2(LOAD_SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(LOAD_SETTLE - 1);
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              latch_q, latch_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wd_hit;

    assign wd_hit        = WD_ON && (count_q == WD_LAST);
    assign cycle_count_o = count_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        latch_d  = latch_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if ((start_req_i || latch_q) && load_done_i) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                    latch_d  = 1'b0;
                    count_d  = '0;
                end else if (start_req_i) begin
                    latch_d = 1'b1;
                end
            end
            S_SETTLE: begin
                // Losing load_done keeps the request pending so RUN still follows once it returns.
                if (!load_done_i) begin
                    state_d = S_IDLE;
                    latch_d = 1'b1;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_RUN: begin
                if (end_process_i) begin
                    state_d = S_READOUT;
                end else begin
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    if (wd_hit) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_READOUT: begin
                if (readout_done_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: begin
                state_d  = S_IDLE;
                settle_d = '0;
                latch_d  = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            settle_q     <= '0;
            latch_q      <= 1'b0;
            count_q      <= '0;
            status_o     <= 2'b00;
            readout_en_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            latch_q      <= latch_d;
            count_q      <= count_d;
            status_o     <= 2'b00;
            readout_en_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
            case (state_d)
                S_SETTLE: busy_o <= 1'b1;
                S_RUN: begin
                    status_o <= 2'b01;
                    busy_o   <= 1'b1;
                end
                S_READOUT: begin
                    status_o     <= 2'b10;
                    readout_en_o <= 1'b1;
                    busy_o       <= 1'b1;
                end
                S_DONE: begin
                    status_o <= 2'b11;
                    done_o   <= 1'b1;
                end
                S_ERROR: begin
                    status_o  <= 2'b11;
                    timeout_o <= WD_ON;
                end
                default: ;
            endcase
        end
    end

endmodule
